lc3_fetch_unit: RTL and testbench
=================================

Name: lc3_fetch_unit

Overview:
Instruction-fetch stage of the LC-3 datapath.
- Maintains PC and runs a read handshake with instruction memory.
- Latches the returned word into IR and holds it until decode accepts it.
- Exposes the raw offset/immediate slices of IR, which feed the sign-extension units directly downstream.
- Accepts a branch/jump redirect, computed downstream from PC plus the sign-extended offset, at the instruction boundary.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
WAIT_LIMIT, 15, maximum consecutive MEM_RDY-low cycles in S_FETCH before a timeout (must be ≥1)
WCNT_W, 4, width of the wait counter (must hold WAIT_LIMIT)

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Run  in  1  enables fetching; sampled in S_IDLE and on IR accept
MEM_ADDR  out  16  fetch address, equals PC
MEM_RD  out  1  read request, high only in S_FETCH
MEM_RDY  in  1  memory has valid MEM_DATA this cycle
MEM_DATA  in  16  instruction word
IR_VALID  out  1  IR holds an unconsumed instruction
IR_ACCEPT  in  1  decode consumes IR this cycle
BR_TAKEN  in  1  redirect request, qualified by IR_VALID & IR_ACCEPT
BR_TARGET  in  16  redirect address
IR  out  16  instruction register
PC  out  16  address of the instruction in IR, plus 1
OPCODE  out  4  IR[15:12]
OFF11  out  11  IR[10:0]
OFF9  out  9  IR[8:0]
OFF6  out  6  IR[5:0]
IMM5  out  5  IR[4:0]
FETCH_ERR  out  1  sticky timeout flag

Behaviour:
Reset (asynchronous, any state, including mid-fetch):
- State = S_IDLE; PC = RESET_PC; IR = 0; wait counter = 0; FETCH_ERR = 0.
- Outputs: MEM_RD = 0, IR_VALID = 0, MEM_ADDR = RESET_PC.
- Any in-flight memory response is discarded.

State machine, registered transitions on rising Clk:
- S_IDLE:
  - Run=1 -> S_FETCH, wait counter cleared.
  - Otherwise stay.
- S_FETCH: MEM_RD=1, MEM_ADDR=PC.
  - MEM_RDY=1: IR<=MEM_DATA; PC<=PC+1 (modulo 2^16, so 16'hFFFF -> 16'h0000); -> S_HOLD.
  - MEM_RDY=0: wait counter +1. If the counter already equals WAIT_LIMIT-1 -> S_ERR.
  - Run is ignored here; an issued fetch always completes or times out.
- S_HOLD: IR_VALID=1; IR and PC stable.
  - IR_ACCEPT=1 and BR_TAKEN=1: PC<=BR_TARGET.
  - IR_ACCEPT=1: next state is S_FETCH if Run=1, else S_IDLE. The wait counter is cleared.
  - IR_ACCEPT=0: hold indefinitely; BR_TAKEN is ignored.
- S_ERR: FETCH_ERR=1, MEM_RD=0, IR_VALID=0. Only reset exits.

Timing:
- Fetch latency is 1 cycle minimum: MEM_RDY high on the first S_FETCH edge gives IR_VALID the next cycle.
- Back-to-back throughput with zero-wait memory and IR_ACCEPT tied high is one instruction per 2 cycles.
- After a taken redirect, MEM_ADDR=BR_TARGET in the first S_FETCH cycle.

Data sampling:
- MEM_DATA is sampled only when MEM_RD & MEM_RDY.
- MEM_RDY outside S_FETCH is ignored.

Outputs:
- Field outputs are pure slices of the IR register, with no extra latency.
- Every output is glitch-free from registers, except MEM_RD, IR_VALID and FETCH_ERR, which decode directly from the state register.

Decomposition:
- lc3_pkg:
  - fetch_state_t enum (S_IDLE, S_FETCH, S_HOLD, S_ERR)
  - opcode localparams (OP_BR, OP_ADD, OP_LD, OP_ST, OP_JSR, OP_AND, OP_LDR, OP_STR, OP_NOT, OP_JMP, OP_LEA, OP_TRAP)
  - field-position localparams for OFF11/OFF9/OFF6/IMM5
- One sub-module, fetch_wait_timer:
  - Inputs: clear, count-enable.
  - Outputs: expired at WAIT_LIMIT.
  - Shares Clk/Reset_n.

Test Plan:
1. Reset, Run=1, zero-wait memory returning 16'h1261, IR_ACCEPT held 0 -> MEM_ADDR=16'h0000 for one cycle; then IR=16'h1261, PC=16'h0001, OPCODE=4'h1, IMM5=5'h01, and IR_VALID stays high while IR_ACCEPT=0.
2. MEM_RDY delayed 3 cycles, WAIT_LIMIT=15 -> MEM_RD high for 4 cycles, IR captured on the 4th, FETCH_ERR=0.
3. IR=16'h0FFD accepted with BR_TAKEN=1, BR_TARGET=16'h0010 -> next MEM_ADDR=16'h0010. The same instruction with BR_TAKEN=0 -> next MEM_ADDR=PC (sequential).
4. MEM_RDY held low -> MEM_RD drops and FETCH_ERR=1 exactly WAIT_LIMIT cycles after S_FETCH entry. FETCH_ERR stays set despite later MEM_RDY or Run, and clears only on Reset_n=0.
5. RESET_PC=16'hFFFF, one fetch -> PC=16'h0000 (wrap). Reset_n pulsed low mid-S_FETCH -> MEM_RD=0 and IR_VALID=0 immediately (asynchronously), PC=RESET_PC.
6. Run dropped while in S_HOLD, then IR_ACCEPT=1 -> return to S_IDLE with no MEM_RD. Run re-raised -> fetch resumes at the retained PC.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 fetch stage.
package lc3_pkg;

   localparam int unsigned XLEN    = 16;
   localparam int unsigned OPC_W   = 4;
   localparam int unsigned OFF11_W = 11;
   localparam int unsigned OFF9_W  = 9;
   localparam int unsigned OFF6_W  = 6;
   localparam int unsigned IMM5_W  = 5;

   // Field positions inside the instruction word
   localparam int unsigned OPC_MSB   = 15;
   localparam int unsigned OPC_LSB   = 12;
   localparam int unsigned OFF11_MSB = 10;
   localparam int unsigned OFF9_MSB  = 8;
   localparam int unsigned OFF6_MSB  = 5;
   localparam int unsigned IMM5_MSB  = 4;

   localparam logic [OPC_W-1:0] OP_BR   = 4'h0;
   localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
   localparam logic [OPC_W-1:0] OP_LD   = 4'h2;
   localparam logic [OPC_W-1:0] OP_ST   = 4'h3;
   localparam logic [OPC_W-1:0] OP_JSR  = 4'h4;
   localparam logic [OPC_W-1:0] OP_AND  = 4'h5;
   localparam logic [OPC_W-1:0] OP_LDR  = 4'h6;
   localparam logic [OPC_W-1:0] OP_STR  = 4'h7;
   localparam logic [OPC_W-1:0] OP_NOT  = 4'h9;
   localparam logic [OPC_W-1:0] OP_JMP  = 4'hC;
   localparam logic [OPC_W-1:0] OP_LEA  = 4'hE;
   localparam logic [OPC_W-1:0] OP_TRAP = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_ERR   = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/lc3_fetch_unit_if.sv
// Instruction-memory read bus plus the IR/decode handshake of the fetch stage.
interface lc3_fetch_unit_if;
   import lc3_pkg::*;

   logic [XLEN-1:0]    MEM_ADDR;
   logic               MEM_RD;
   logic               MEM_RDY;
   logic [XLEN-1:0]    MEM_DATA;
   logic               IR_VALID;
   logic               IR_ACCEPT;
   logic               BR_TAKEN;
   logic [XLEN-1:0]    BR_TARGET;
   logic [XLEN-1:0]    IR;
   logic [XLEN-1:0]    PC;
   logic [OPC_W-1:0]   OPCODE;
   logic [OFF11_W-1:0] OFF11;
   logic [OFF9_W-1:0]  OFF9;
   logic [OFF6_W-1:0]  OFF6;
   logic [IMM5_W-1:0]  IMM5;

   modport master (
      output MEM_ADDR, MEM_RD, IR_VALID, IR, PC, OPCODE, OFF11, OFF9, OFF6, IMM5,
      input  MEM_RDY, MEM_DATA, IR_ACCEPT, BR_TAKEN, BR_TARGET
   );

   modport slave (
      input  MEM_ADDR, MEM_RD, IR_VALID, IR, PC, OPCODE, OFF11, OFF9, OFF6, IMM5,
      output MEM_RDY, MEM_DATA, IR_ACCEPT, BR_TAKEN, BR_TARGET
   );

endinterface

// File: rtl/fetch_wait_timer.sv
// Counts consecutive memory wait cycles of one fetch; flags the cycle that reaches the limit.
module fetch_wait_timer #(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned WCNT_W     = 4
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic clear,
   input  logic count_en,
   output logic expired_c
);

   logic [WCNT_W-1:0] cnt;

   // Wait counter: cleared at each fetch start, advanced on every stalled cycle
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (count_en)
         cnt <= cnt + WCNT_W'(1);
   end

   // This stalled cycle is the WAIT_LIMIT-th one
   assign expired_c = count_en && (cnt == WCNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch: PC, memory read handshake, IR latch and redirect.
module lc3_fetch_unit
   import lc3_pkg::*;
#(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned WCNT_W     = 4
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Run,
   output logic FETCH_ERR,
   lc3_fetch_unit_if.master bus
);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] ir;
   logic            wt_clear;
   logic            wt_count;
   logic            wt_expired_c;

   assign wt_clear = ((state == S_IDLE) && Run) || ((state == S_HOLD) && bus.IR_ACCEPT);
   assign wt_count = (state == S_FETCH) && !bus.MEM_RDY;

   fetch_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .WCNT_W     (WCNT_W)
   ) u_wait_timer (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .clear     (wt_clear),
      .count_en  (wt_count),
      .expired_c (wt_expired_c)
   );

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; an issued fetch always completes or times out regardless of Run
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (Run) state_nxt = S_FETCH;
         S_FETCH: begin
            if (bus.MEM_RDY)
               state_nxt = S_HOLD;
            else if (wt_expired_c)
               state_nxt = S_ERR;
         end
         S_HOLD:  if (bus.IR_ACCEPT) state_nxt = Run ? S_FETCH : S_IDLE;
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State-decoded status outputs
   always_comb begin
      bus.MEM_RD   = 1'b0;
      bus.IR_VALID = 1'b0;
      FETCH_ERR    = 1'b0;
      unique case (state)
         S_FETCH: bus.MEM_RD   = 1'b1;
         S_HOLD:  bus.IR_VALID = 1'b1;
         S_ERR:   FETCH_ERR    = 1'b1;
         default: ;
      endcase
   end

   // PC and IR: capture on memory response, redirect on accepted taken branch
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pc <= RESET_PC;
         ir <= '0;
      end else if ((state == S_FETCH) && bus.MEM_RDY) begin
         ir <= bus.MEM_DATA;
         pc <= pc + XLEN'(1);
      end else if ((state == S_HOLD) && bus.IR_ACCEPT && bus.BR_TAKEN) begin
         pc <= bus.BR_TARGET;
      end
   end

   assign bus.MEM_ADDR = pc;
   assign bus.PC       = pc;
   assign bus.IR       = ir;
   assign bus.OPCODE   = ir[OPC_MSB:OPC_LSB];
   assign bus.OFF11    = ir[OFF11_MSB:0];
   assign bus.OFF9     = ir[OFF9_MSB:0];
   assign bus.OFF6     = ir[OFF6_MSB:0];
   assign bus.IMM5     = ir[IMM5_MSB:0];

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed bench for lc3_fetch_unit: vector table plus timeout, reset and PC-wrap sequences.
module tb_lc3_fetch_unit;

   logic Clk;
   logic rst_n, rst_w_n;
   logic run, run_w;
   logic err, err_w;

   int total = 0;
   int bad   = 0;

   lc3_fetch_unit_if bus ();
   lc3_fetch_unit_if bus_w ();

   lc3_fetch_unit #(
      .RESET_PC   (16'h0000),
      .WAIT_LIMIT (15),
      .WCNT_W     (4)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (rst_n),
      .Run       (run),
      .FETCH_ERR (err),
      .bus       (bus.master)
   );

   lc3_fetch_unit #(
      .RESET_PC   (16'hFFFF),
      .WAIT_LIMIT (3),
      .WCNT_W     (2)
   ) dut_w (
      .Clk       (Clk),
      .Reset_n   (rst_w_n),
      .Run       (run_w),
      .FETCH_ERR (err_w),
      .bus       (bus_w.master)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      logic        run;
      logic        rdy;
      logic [15:0] data;
      logic        acc;
      logic        br;
      logic [15:0] tgt;
      logic        e_rd;
      logic        e_irv;
      logic [15:0] e_pc;
      logic [15:0] e_ir;
   } vec_t;

   localparam int NV = 19;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      //           run rdy data     acc br tgt       rd irv pc       ir
      vec[0]  = '{1, 1, 16'h1261, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000};
      vec[1]  = '{1, 1, 16'h1261, 0, 0, 16'h0000, 0, 1, 16'h0001, 16'h1261};
      vec[2]  = '{1, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 1, 16'h0001, 16'h1261};
      vec[3]  = '{1, 0, 16'h0000, 0, 1, 16'h0050, 0, 1, 16'h0001, 16'h1261};
      vec[4]  = '{1, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0001, 16'h1261};
      vec[5]  = '{1, 1, 16'h0FFD, 0, 0, 16'h0000, 0, 1, 16'h0002, 16'h0FFD};
      vec[6]  = '{1, 0, 16'h0000, 1, 1, 16'h0010, 1, 0, 16'h0010, 16'h0FFD};
      vec[7]  = '{1, 1, 16'h0FFD, 0, 0, 16'h0000, 0, 1, 16'h0011, 16'h0FFD};
      vec[8]  = '{1, 0, 16'h0000, 1, 0, 16'h0010, 1, 0, 16'h0011, 16'h0FFD};
      vec[9]  = '{1, 0, 16'h3A5B, 0, 0, 16'h0000, 1, 0, 16'h0011, 16'h0FFD};
      vec[10] = '{1, 0, 16'h3A5B, 0, 0, 16'h0000, 1, 0, 16'h0011, 16'h0FFD};
      vec[11] = '{1, 0, 16'h3A5B, 0, 0, 16'h0000, 1, 0, 16'h0011, 16'h0FFD};
      vec[12] = '{1, 1, 16'h3A5B, 0, 0, 16'h0000, 0, 1, 16'h0012, 16'h3A5B};
      vec[13] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0012, 16'h3A5B};
      vec[14] = '{0, 1, 16'h7777, 1, 0, 16'h0000, 0, 0, 16'h0012, 16'h3A5B};
      vec[15] = '{0, 1, 16'h7777, 0, 0, 16'h0000, 0, 0, 16'h0012, 16'h3A5B};
      vec[16] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0012, 16'h3A5B};
      vec[17] = '{1, 1, 16'h5123, 0, 0, 16'h0000, 0, 1, 16'h0013, 16'h5123};
      vec[18] = '{1, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0013, 16'h5123};

      rst_n = 1'b0;
      rst_w_n = 1'b0;
      run = 1'b0;
      run_w = 1'b0;
      bus.MEM_RDY = 1'b0;   bus.MEM_DATA = '0;   bus.IR_ACCEPT = 1'b0;
      bus.BR_TAKEN = 1'b0;  bus.BR_TARGET = '0;
      bus_w.MEM_RDY = 1'b0; bus_w.MEM_DATA = '0; bus_w.IR_ACCEPT = 1'b0;
      bus_w.BR_TAKEN = 1'b0; bus_w.BR_TARGET = '0;

      #12;
      chk("rst_mem_rd",   32'(bus.MEM_RD),   32'h0);
      chk("rst_ir_valid", 32'(bus.IR_VALID), 32'h0);
      chk("rst_mem_addr", 32'(bus.MEM_ADDR), 32'h0000);
      chk("rst_ir",       32'(bus.IR),       32'h0000);
      chk("rst_fetch_err", 32'(err),         32'h0);
      chk("rst_w_addr",   32'(bus_w.MEM_ADDR), 32'hFFFF);
      rst_n = 1'b1;
      rst_w_n = 1'b1;

      // Main vector table: sequential fetch, stall, redirect, Run drop/resume
      for (int i = 0; i < NV; i++) begin
         run = vec[i].run;
         bus.MEM_RDY = vec[i].rdy;
         bus.MEM_DATA = vec[i].data;
         bus.IR_ACCEPT = vec[i].acc;
         bus.BR_TAKEN = vec[i].br;
         bus.BR_TARGET = vec[i].tgt;
         step();
         chk($sformatf("v%0d_mem_rd", i),   32'(bus.MEM_RD),   32'(vec[i].e_rd));
         chk($sformatf("v%0d_ir_valid", i), 32'(bus.IR_VALID), 32'(vec[i].e_irv));
         chk($sformatf("v%0d_mem_addr", i), 32'(bus.MEM_ADDR), 32'(vec[i].e_pc));
         chk($sformatf("v%0d_pc", i),       32'(bus.PC),       32'(vec[i].e_pc));
         chk($sformatf("v%0d_ir", i),       32'(bus.IR),       32'(vec[i].e_ir));
         chk($sformatf("v%0d_fetch_err", i), 32'(err),         32'h0);
         if (i == 1) begin
            chk("f_opcode", 32'(bus.OPCODE), 32'h1);
            chk("f_off11",  32'(bus.OFF11),  32'h261);
            chk("f_off9",   32'(bus.OFF9),   32'h061);
            chk("f_off6",   32'(bus.OFF6),   32'h21);
            chk("f_imm5",   32'(bus.IMM5),   32'h01);
         end
      end

      // Timeout: vector 18 entered S_FETCH; memory never answers
      bus.IR_ACCEPT = 1'b0;
      bus.MEM_RDY = 1'b0;
      for (int k = 1; k < 15; k++) begin
         step();
         chk($sformatf("to%0d_mem_rd", k), 32'(bus.MEM_RD), 32'h1);
         chk($sformatf("to%0d_err", k),    32'(err),        32'h0);
      end
      step();
      chk("to15_mem_rd",   32'(bus.MEM_RD),   32'h0);
      chk("to15_err",      32'(err),          32'h1);
      chk("to15_ir_valid", 32'(bus.IR_VALID), 32'h0);
      bus.MEM_RDY = 1'b1;
      bus.MEM_DATA = 16'h1111;
      bus.IR_ACCEPT = 1'b1;
      run = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("sticky%0d_err", k),    32'(err),        32'h1);
         chk($sformatf("sticky%0d_mem_rd", k), 32'(bus.MEM_RD), 32'h0);
         chk($sformatf("sticky%0d_ir", k),     32'(bus.IR),     32'h5123);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("err_clr_err", 32'(err), 32'h0);
      chk("err_clr_pc",  32'(bus.PC), 32'h0000);

      // Asynchronous reset in the middle of a fetch
      run = 1'b1;
      bus.MEM_RDY = 1'b1;
      bus.MEM_DATA = 16'h2A00;
      bus.IR_ACCEPT = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("mid_hold_pc", 32'(bus.PC), 32'h0001);
      bus.IR_ACCEPT = 1'b1;
      bus.MEM_RDY = 1'b0;
      step();
      chk("mid_fetch_rd",   32'(bus.MEM_RD),   32'h1);
      chk("mid_fetch_addr", 32'(bus.MEM_ADDR), 32'h0001);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_mem_rd",   32'(bus.MEM_RD),   32'h0);
      chk("async_ir_valid", 32'(bus.IR_VALID), 32'h0);
      chk("async_mem_addr", 32'(bus.MEM_ADDR), 32'h0000);
      chk("async_ir",       32'(bus.IR),       32'h0000);

      // PC wrap and short timeout on the RESET_PC=FFFF, WAIT_LIMIT=3 instance
      run_w = 1'b1;
      bus_w.MEM_RDY = 1'b1;
      bus_w.MEM_DATA = 16'hF025;
      step();
      chk("w_fetch_rd",   32'(bus_w.MEM_RD),   32'h1);
      chk("w_fetch_addr", 32'(bus_w.MEM_ADDR), 32'hFFFF);
      step();
      chk("w_pc_wrap",    32'(bus_w.PC),     32'h0000);
      chk("w_ir",         32'(bus_w.IR),     32'hF025);
      chk("w_opcode",     32'(bus_w.OPCODE), 32'hF);
      chk("w_ir_valid",   32'(bus_w.IR_VALID), 32'h1);
      bus_w.IR_ACCEPT = 1'b1;
      bus_w.MEM_RDY = 1'b0;
      step();
      chk("w_refetch_addr", 32'(bus_w.MEM_ADDR), 32'h0000);
      bus_w.IR_ACCEPT = 1'b0;
      step();
      chk("w_wait1_rd", 32'(bus_w.MEM_RD), 32'h1);
      step();
      chk("w_wait2_rd",  32'(bus_w.MEM_RD), 32'h1);
      chk("w_wait2_err", 32'(err_w),        32'h0);
      step();
      chk("w_to_rd",  32'(bus_w.MEM_RD), 32'h0);
      chk("w_to_err", 32'(err_w),        32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
